// File: rtl/mul_iter_64_pkg.sv
// mul_iter_64_pkg: shared width, FSM encoding and mul opcode constants
package mul_iter_64_pkg;
  localparam int WIDTH = 64;
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY  = 3'd1,
    FIX_A = 3'd2,
    FIX_B = 3'd3,
    DONE  = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_UMULH = 2'd1,
    OP_SMULH = 2'd2
  } mul_op_t;
  function automatic logic op_signed(input mul_op_t op);
    return op == OP_SMULH;
  endfunction
endpackage

// File: rtl/CLA_64bit.sv
// CLA_64bit: 64-bit parallel-prefix carry-lookahead adder with carry in/out
module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [63:0] p0, c;
  assign p0 = a ^ b;
  genvar k;
  for (k = 0; k <= 6; k++) begin : lv
    logic [63:0] g, p;
    if (k == 0) begin : base
      assign g = a & b;
      assign p = p0;
    end else begin : comb
      assign g = lv[k-1].g | (lv[k-1].p & (lv[k-1].g << (1 << (k - 1))));
      assign p = lv[k-1].p & ((lv[k-1].p << (1 << (k - 1))) | ((64'd1 << (1 << (k - 1))) - 64'd1));
    end
  end
  assign c = {lv[6].g[62:0], cin} | ({lv[6].p[62:0], 1'b0} & {64{cin}});
  assign sum = p0 ^ c;
  assign cout = lv[6].g[63] | (lv[6].p[63] & cin);
endmodule

// File: rtl/mul_iter_64.sv
// mul_iter_64: iterative radix-2 shift-add multiplier with fixed two-cycle signed correction
module mul_iter_64
  import mul_iter_64_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, mplr, b_lat, hi, add_b, sum;
  logic [CNT_W-1:0] count;
  logic neg_a, neg_b, cout;
  // one adder serves the accumulate step and both two's-complement subtracts
  assign add_b = state == BUSY  ? (mplr[0] ? mcand : '0) :
                 state == FIX_A ? ~(neg_a ? b_lat : '0) :
                                  ~(neg_b ? mcand : '0);
  CLA_64bit u_add (
    .a(hi),
    .b(add_b),
    .cin(state != BUSY),
    .sum(sum),
    .cout(cout)
  );
  always_comb begin
    state_n = state == IDLE  ? (start ? BUSY : IDLE) :
              state == BUSY  ? (count == CNT_W'(WIDTH - 1) ? FIX_A : BUSY) :
              state == FIX_A ? FIX_B :
              state == FIX_B ? DONE : IDLE;
    ready = state == IDLE;
    valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi    <= '0;
      mplr  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        mcand <= a;
        mplr  <= b;
        b_lat <= b;
        neg_a <= is_signed & a[WIDTH-1];
        neg_b <= is_signed & b[WIDTH-1];
        hi    <= '0;
        count <= '0;
      end else if (state == BUSY) begin
        {hi, mplr} <= {cout, sum, mplr[WIDTH-1:1]};
        count      <= count + 1'b1;
      end else if (state == FIX_A || state == FIX_B) begin
        hi <= sum;
      end
    end
  end
  assign result_hi = hi;
  assign result_lo = mplr;
endmodule

// File: tb/tb_mul_iter_64.sv
// tb_mul_iter_64: directed and model-checked vectors for the iterative multiplier
module tb_mul_iter_64;
  logic clk = 0, reset = 1, start = 0, is_signed = 0;
  logic [63:0] a = 0, b = 0;
  logic ready, valid;
  logic [63:0] result_hi, result_lo;
  int checks = 0, failures = 0;

  mul_iter_64 dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .ready(ready), .valid(valid),
    .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic signed [127:0] sx, sy;
    sx = s ? {{64{x[63]}}, x} : {64'b0, x};
    sy = s ? {{64{y[63]}}, y} : {64'b0, y};
    return sx * sy;
  endfunction

  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic s, input logic [63:0] eh, input logic [63:0] el);
    int t, n;
    t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, ready, 1);
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1;
    @(posedge clk);
    #1 check({tag, "_busy"}, ready, 0);
    @(negedge clk);
    start = 0; a = {$urandom, $urandom}; b = ~x; is_signed = ~s;
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, n, 66);
    check({tag, "_hi"}, result_hi, eh);
    check({tag, "_lo"}, result_lo, el);
    @(posedge clk);
    #1 check({tag, "_end"}, {valid, ready}, 2'b01);
  endtask

  task automatic held_start();
    logic [63:0] qa [3], qb [3];
    logic [127:0] qe [3];
    int k, got, last;
    qa[0] = 64'd10; qb[0] = 64'd20; qe[0] = 128'd200;
    qa[1] = 64'hFFFF_FFFF_FFFF_FFFF; qb[1] = 64'd2; qe[1] = {64'h1, 64'hFFFF_FFFF_FFFF_FFFE};
    qa[2] = 64'd123456789; qb[2] = 64'd1000; qe[2] = 128'h1C_BE99_1A08;
    k = 0; got = 0; last = 0;
    start = 1;
    for (int c = 0; c < 400 && got < 3; c++) begin
      @(negedge clk);
      if (ready && k < 3) begin
        a = qa[k]; b = qb[k]; is_signed = 0; k++;
      end else begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; is_signed = 1;
      end
      @(posedge clk);
      #1;
      if (valid) begin
        check($sformatf("held%0d", got), {result_hi, result_lo}, qe[got]);
        if (got > 0) check($sformatf("held_gap%0d", got), c - last, 68);
        last = c;
        got++;
      end
    end
    start = 0;
    check("held_count", got, 3);
  endtask

  initial begin
    int pulses;
    logic [63:0] x, y;
    logic s;
    logic [127:0] e;
    repeat (3) @(posedge clk);
    #1 check("rst_state", {ready, valid, result_hi, result_lo}, {2'b10, 128'd0});
    @(negedge clk) reset = 0;
    run_op("u3x5", 64'd3, 64'd5, 0, 64'd0, 64'hF);
    run_op("usq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
    run_op("sm2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("um2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0,
           64'h2, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("sm1sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 64'd1);
    run_op("sminsq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1,
           64'h4000_0000_0000_0000, 64'd0);
    @(negedge clk);
    a = 64'd11; b = 64'd13; is_signed = 0; start = 1;
    @(posedge clk);
    @(negedge clk) start = 0;
    repeat (29) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 check("rst_mid", {ready, valid, result_hi, result_lo}, {2'b10, 128'd0});
    @(negedge clk) reset = 0;
    pulses = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (valid) pulses++;
    end
    check("rst_no_valid", pulses, 0);
    run_op("u7x9", 64'd7, 64'd9, 0, 64'd0, 64'd63);
    @(negedge clk);
    reset = 1; start = 1; a = 64'd5; b = 64'd5;
    @(posedge clk);
    #1 check("rst_start_a", ready, 1);
    @(negedge clk);
    reset = 0; start = 0;
    @(posedge clk);
    #1 check("rst_start_b", {ready, result_lo}, {1'b1, 64'd0});
    held_start();
    for (int i = 0; i < 150; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 10 == 0) x = {1'b1, 63'd0};
      if (i % 7 == 0) y = '1;
      s = i[0];
      e = model(x, y, s);
      run_op($sformatf("rnd%0d", i), x, y, s, e[127:64], e[63:0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
